random_inject_ctrl: RTL and testbench

- Downstream consumer of the LFSR range-check generators (e.g. the 90..127 window, ~30% hit rate).
- Turns their one-bit `valid` stream into a bounded stream of timestamped, sequence-numbered packet descriptors on a valid/ready interface.
- Buffers descriptors in a small FIFO so a stalled sink does not lose injections until the buffer overflows; overflows are counted as drops.
- A run/drain/done state machine bounds each experiment to a fixed number of offered injections.

---
 rtl/random_inject_ctrl.sv | 173 +++++++++++++++++
 tb/tb_random_inject_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/random_inject_ctrl.sv
// random_inject_ctrl
//   Turns a one-bit injection request stream (typically the `valid` of an
//   LFSR range-check generator) into timestamped, sequence-numbered packet
//   descriptors on a valid/ready interface. Descriptors are buffered in a
//   small circular FIFO; requests that find the FIFO full are counted as
//   drops. A run/drain/done state machine bounds each experiment to
//   PKT_LIMIT offered injections (0 = unlimited, ended only by `stop`).
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   inject     in   injection request, sampled every cycle (used only in RUN)
//   start      in   one-cycle pulse, begins a run from IDLE or DONE
//   stop       in   one-cycle pulse, ends RUN early
//   out_ready  in   sink accepts the head descriptor
//   out_valid  out  FIFO non-empty
//   out_data   out  head descriptor {seq_id, ts}
//   busy       out  state is RUN or DRAIN
//   done       out  state is DONE
//   drop_cnt   out  injections lost to a full FIFO, saturating
//   level      out  FIFO occupancy, 0..DEPTH
module random_inject_ctrl #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ID_W      = 8,
  parameter int unsigned TS_W      = 16,
  parameter logic [15:0] PKT_LIMIT = 16'd1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inject,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [ID_W+TS_W-1:0]    out_data,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             drop_cnt,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned DW = ID_W + TS_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [TS_W-1:0]   ts_r;
  logic [ID_W-1:0]   seq_id_r;
  logic [15:0]       offered_r;
  logic [15:0]       drop_r;
  logic [DW-1:0]     mem_r [DEPTH];
  logic [AW-1:0]     wptr_r;
  logic [AW-1:0]     rptr_r;
  logic [LW-1:0]     level_r;

  logic              pop_s;
  logic              full_s;
  logic              offer_s;
  logic              push_s;
  logic              run_start_s;
  logic              limit_hit_s;
  logic [15:0]       offered_nxt_s;
  logic [LW-1:0]     level_nxt_s;

  // Handshake and FIFO bookkeeping derived from registered state.
  always_comb begin
    pop_s         = (level_r != LW'(0)) && out_ready;
    full_s        = (level_r == LW'(DEPTH));
    offer_s       = (state_r == RUN) && inject;
    // A full FIFO still accepts when the head leaves on the same edge.
    push_s        = offer_s && (!full_s || pop_s);
    run_start_s   = ((state_r == IDLE) || (state_r == DONE)) && start;
    offered_nxt_s = offered_r + 16'd1;
    limit_hit_s   = offer_s && (PKT_LIMIT != 16'd0) && (offered_nxt_s == PKT_LIMIT);
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // Next-state logic for the run/drain/done controller.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        // The limiting (or stop-coincident) injection is processed first.
        if (stop || limit_hit_s) state_s = DRAIN;
        else                     state_s = RUN;
      end
      DRAIN: begin
        // Leave on the edge where the last entry is popped.
        if (level_nxt_s == LW'(0)) state_s = DONE;
        else                       state_s = DRAIN;
      end
      DONE: begin
        if (start) state_s = RUN;
        else       state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Timestamp, sequence number and injection counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_r      <= '0;
      seq_id_r  <= '0;
      offered_r <= 16'd0;
      drop_r    <= 16'd0;
    end else if (run_start_s) begin
      ts_r      <= '0;
      seq_id_r  <= '0;
      offered_r <= 16'd0;
      drop_r    <= 16'd0;
    end else begin
      ts_r <= ts_r + TS_W'(1);
      if (offer_s) begin
        offered_r <= offered_nxt_s;
        if (push_s) begin
          seq_id_r <= seq_id_r + ID_W'(1);
        end else if (drop_r != 16'hFFFF) begin
          drop_r <= drop_r + 16'd1;
        end
      end
    end
  end

  // Circular FIFO storage and pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_r[i] <= '0;
      wptr_r  <= '0;
      rptr_r  <= '0;
      level_r <= '0;
    end else begin
      if (push_s) begin
        mem_r[wptr_r] <= {seq_id_r, ts_r};
        wptr_r        <= wptr_r + AW'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + AW'(1);
      end
      level_r <= level_nxt_s;
    end
  end

  assign out_valid = (level_r != LW'(0));
  assign out_data  = mem_r[rptr_r];
  assign busy      = (state_r == RUN) || (state_r == DRAIN);
  assign done      = (state_r == DONE);
  assign drop_cnt  = drop_r;
  assign level     = level_r;

endmodule

// File: tb/tb_random_inject_ctrl.sv
// Self-checking bench for random_inject_ctrl (DEPTH=4, ID_W=2, TS_W=4,
// PKT_LIMIT=6 so id and timestamp wrap are reached inside short runs).
// A cycle model pushes expected descriptors on every accepted injection;
// a monitor pops and compares whenever the DUT hands a descriptor over.
module tb_random_inject_ctrl;

  localparam int DEPTH = 4;
  localparam int ID_W  = 2;
  localparam int TS_W  = 4;
  localparam logic [15:0] LIMIT = 16'd6;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic        clk;
  logic        rst;
  logic        inject;
  logic        start;
  logic        stop;
  logic        out_ready;
  logic        out_valid;
  logic [5:0]  out_data;
  logic        busy;
  logic        done;
  logic [15:0] drop_cnt;
  logic [2:0]  level;

  int errors = 0;
  int checks = 0;
  int pop_cnt = 0;

  random_inject_ctrl #(
    .DEPTH(DEPTH), .ID_W(ID_W), .TS_W(TS_W), .PKT_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .inject(inject), .start(start), .stop(stop),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .busy(busy), .done(done), .drop_cnt(drop_cnt), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [1:0]  m_state;
  logic [1:0]  m_prev;
  int          m_lvl;
  logic [3:0]  m_ts;
  logic [3:0]  m_ts_now;
  logic [1:0]  m_seq;
  int          m_off;
  int          m_drop;
  bit          m_pop;
  logic [5:0]  exp_q[$];
  logic [5:0]  exp_d;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = S_IDLE; m_lvl = 0; m_ts = 4'd0; m_seq = 2'd0;
      m_off = 0; m_drop = 0; exp_q.delete();
    end else begin
      m_prev   = m_state;
      m_pop    = (m_lvl > 0) && out_ready;
      m_ts_now = m_ts;
      m_ts     = m_ts + 4'd1;
      case (m_prev)
        S_IDLE, S_DONE: begin
          if (start) begin
            m_state = S_RUN; m_ts = 4'd0; m_seq = 2'd0; m_off = 0; m_drop = 0;
          end
        end
        S_RUN: begin
          if (inject) begin
            m_off++;
            if (m_lvl < DEPTH || m_pop) begin
              exp_q.push_back({m_seq, m_ts_now});
              m_seq = m_seq + 2'd1;
              m_lvl++;
            end else if (m_drop < 65535) begin
              m_drop++;
            end
          end
          if (stop || (inject && m_off == int'(LIMIT))) m_state = S_DRAIN;
        end
        default: ;
      endcase
      if (m_pop) m_lvl--;
      if (m_prev == S_DRAIN && m_lvl == 0) m_state = S_DONE;
    end
  end

  // Monitor: compare handed-over descriptors and status against the model.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (out_valid !== (m_lvl != 0)) begin
        errors++;
        $display("FAIL out_valid: got %0b want %0b", out_valid, (m_lvl != 0));
      end
      checks++;
      if (level !== 3'(m_lvl) || drop_cnt !== 16'(m_drop)) begin
        errors++;
        $display("FAIL level/drop: got %0d/%0d want %0d/%0d", level, drop_cnt, m_lvl, m_drop);
      end
      checks++;
      if (done !== (m_state == S_DONE) || busy !== (m_state == S_RUN || m_state == S_DRAIN)) begin
        errors++;
        $display("FAIL busy/done: got %0b/%0b want state %0d", busy, done, m_state);
      end
      if (out_valid && out_ready) begin
        checks++;
        pop_cnt++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_data: got %h want nothing (queue empty)", out_data);
        end else begin
          exp_d = exp_q.pop_front();
          if (out_data !== exp_d) begin
            errors++;
            $display("FAIL pop_data: got id=%0d ts=%0d want id=%0d ts=%0d",
                     out_data[5:4], out_data[3:0], exp_d[5:4], exp_d[3:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 6'd0 || busy !== 1'b0 || done !== 1'b0 ||
        drop_cnt !== 16'd0 || level !== 3'd0) begin
      errors++;
      $display("FAIL reset_values: got v=%0b d=%h b=%0b dn=%0b drop=%0d lvl=%0d want all 0",
               out_valid, out_data, busy, done, drop_cnt, level);
    end
  endtask

  task automatic test_basic();
    int base;
    base = pop_cnt;
    out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %0b want 1", busy); end
    inject = 1'b1;
    repeat (6) tick();
    inject = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL basic_drain: got busy=%0b done=%0b want 1/0", busy, done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || level !== 3'd0 || drop_cnt !== 16'd0) begin
      errors++; $display("FAIL basic_done: got done=%0b lvl=%0d drop=%0d want 1/0/0", done, level, drop_cnt);
    end
    checks++;
    if (pop_cnt - base !== 6) begin
      errors++; $display("FAIL basic_count: got %0d want 6", pop_cnt - base);
    end
  endtask

  task automatic test_overflow();
    logic [5:0] held;
    out_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    inject = 1'b1;
    repeat (6) tick();
    inject = 1'b0;
    checks++;
    if (level !== 3'd4 || drop_cnt !== 16'd2 || busy !== 1'b1) begin
      errors++; $display("FAIL ovf_level: got lvl=%0d drop=%0d busy=%0b want 4/2/1", level, drop_cnt, busy);
    end
    held = out_data;
    repeat (3) tick();
    checks++;
    if (out_data !== held || out_data !== 6'h00) begin
      errors++; $display("FAIL ovf_hold: got %h want 00", out_data);
    end
    out_ready = 1'b1;
    repeat (4) tick();
    checks++;
    if (done !== 1'b1 || level !== 3'd0) begin
      errors++; $display("FAIL ovf_done: got done=%0b lvl=%0d want 1/0", done, level);
    end
  endtask

  task automatic test_full_pop();
    out_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    inject = 1'b1;
    repeat (4) tick();
    out_ready = 1'b1;
    tick();
    inject = 1'b0; out_ready = 1'b0;
    checks++;
    if (level !== 3'd4 || drop_cnt !== 16'd0) begin
      errors++; $display("FAIL fullpop: got lvl=%0d drop=%0d want 4/0", level, drop_cnt);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL fullpop_done: got %0b want 1", done); end
  endtask

  task automatic test_stop();
    int base;
    int n_inj;
    base = pop_cnt;
    n_inj = 0;
    out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      inject = (n_inj < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      start  = (i == 3);
      tick();
      if (inject) n_inj++;
    end
    start = 1'b0;
    stop = 1'b1; inject = 1'b1; tick(); n_inj++;
    stop = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL stop_drain: got busy=%0b done=%0b want 1/0", busy, done);
    end
    repeat (3) tick();
    inject = 1'b0;
    repeat (2) tick();
    checks++;
    if (done !== 1'b1 || drop_cnt !== 16'd0 || level !== 3'd0) begin
      errors++; $display("FAIL stop_done: got done=%0b drop=%0d lvl=%0d want 1/0/0", done, drop_cnt, level);
    end
    checks++;
    if (pop_cnt - base !== n_inj) begin
      errors++; $display("FAIL stop_count: got %0d want %0d", pop_cnt - base, n_inj);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL stop_ignored: got done=%0b want 1", done); end
  endtask

  task automatic test_ts_wrap();
    out_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (17) tick();
    inject = 1'b1; tick(); inject = 1'b0;
    checks++;
    if (out_data !== {2'd0, 4'd1}) begin
      errors++; $display("FAIL ts_wrap: got id=%0d ts=%0d want id=0 ts=1", out_data[5:4], out_data[3:0]);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    inject = 1'b1; repeat (3) tick(); inject = 1'b0;
    checks++;
    if (level !== 3'd3) begin errors++; $display("FAIL mid_level: got %0d want 3", level); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || level !== 3'd0 || busy !== 1'b0 || drop_cnt !== 16'd0 || done !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got v=%0b lvl=%0d busy=%0b drop=%0d want 0", out_valid, level, busy, drop_cnt);
    end
    #3 rst = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    inject = 1'b1; tick(); inject = 1'b0;
    checks++;
    if (out_data !== 6'h00 || level !== 3'd1) begin
      errors++; $display("FAIL restart: got data=%h lvl=%0d want 00/1", out_data, level);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL restart_done: got %0b want 1", done); end
  endtask

  initial begin
    rst = 1'b1; inject = 1'b0; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
    #12 rst = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_overflow();
    test_full_pop();
    test_stop();
    test_ts_wrap();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL leftover: got %0d queued want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
